// File: rtl/tlb_lookup_arbiter.sv
// Purpose: shares one combinational TLB lookup port between instruction-fetch (I) and load/store (D) requesters.
// Latency: accept in T, TLB strobe in T+1, registered response valid from T+2 until taken (max 1 request per 3 cycles).
// Backpressure: requests are accepted only in IDLE; the response is held stable until the owning port asserts resp_ready.
module tlb_lookup_arbiter #(
    parameter int D_PRIORITY = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             i_req_valid,
    output logic             i_req_ready,
    input  logic [31:0]      i_vaddr,
    input  logic             i_flush,
    output logic             i_resp_valid,
    input  logic             i_resp_ready,

    input  logic             d_req_valid,
    output logic             d_req_ready,
    input  logic [31:0]      d_vaddr,
    input  logic             d_is_store,
    output logic             d_resp_valid,
    input  logic             d_resp_ready,

    output logic             resp_hit,
    output logic [31:0]      resp_paddr,
    output logic             resp_exc_valid,
    output logic [4:0]       resp_exc_code,

    output logic             tlb_req_valid,
    output logic [31:0]      tlb_vaddr,
    output logic             tlb_is_store,
    input  logic             tlb_hit,
    input  logic [31:0]      tlb_paddr,
    input  logic             tlb_exc_valid,
    input  logic [4:0]       tlb_exc_code,

    output logic [CNT_W-1:0] i_lookup_cnt,
    output logic [CNT_W-1:0] d_lookup_cnt,
    output logic [CNT_W-1:0] exc_cnt
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOOKUP = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Port identifiers used for owner and rr_ptr.
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        owner;
    logic        rr_ptr;
    logic [31:0] lat_vaddr;
    logic        lat_is_store;

    logic        i_cand;
    logic        d_cand;
    logic        grant_any;
    logic        grant_d;
    logic        flush_kill;
    logic        resp_fire;
    logic        in_idle;
    logic        in_lookup;
    logic        in_resp;

    assign in_idle   = (state == ST_IDLE);
    assign in_lookup = (state == ST_LOOKUP);
    assign in_resp   = (state == ST_RESP);

    // A flush in IDLE removes the I request from arbitration for that cycle.
    assign i_cand = i_req_valid && !i_flush;
    assign d_cand = d_req_valid;

    // Arbitration: single requester wins outright; on contention D wins under
    // fixed priority, otherwise the port named by rr_ptr wins.
    always_comb begin
        grant_any = 1'b0;
        grant_d   = OWN_I;
        if (in_idle && !rst) begin
            if (i_cand && d_cand) begin
                grant_any = 1'b1;
                grant_d   = (D_PRIORITY != 0) ? OWN_D : rr_ptr;
            end else if (i_cand) begin
                grant_any = 1'b1;
                grant_d   = OWN_I;
            end else if (d_cand) begin
                grant_any = 1'b1;
                grant_d   = OWN_D;
            end
        end
    end

    assign i_req_ready = grant_any && (grant_d == OWN_I);
    assign d_req_ready = grant_any && (grant_d == OWN_D);

    // An I flush only kills a transaction that I owns; D traffic ignores it.
    assign flush_kill = i_flush && (owner == OWN_I) && (in_lookup || in_resp);

    // The response handshake only counts for the owning port's resp_ready.
    assign resp_fire = in_resp && !flush_kill &&
                       ((owner == OWN_D) ? d_resp_ready : i_resp_ready);

    // Masking i_resp_valid with i_flush guarantees no I handshake in a flush cycle.
    assign i_resp_valid = in_resp && (owner == OWN_I) && !i_flush;
    assign d_resp_valid = in_resp && (owner == OWN_D);

    // The TLB sees the latched request; only the strobe is state-dependent.
    assign tlb_req_valid = in_lookup;
    assign tlb_vaddr     = lat_vaddr;
    assign tlb_is_store  = lat_is_store;

    // Next-state selection for the IDLE -> LOOKUP -> RESP sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (grant_any) begin
                    state_nxt = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                state_nxt = flush_kill ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
                if (flush_kill || resp_fire) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the winning request and advance the round-robin pointer at accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner        <= OWN_I;
            rr_ptr       <= OWN_I;
            lat_vaddr    <= 32'd0;
            lat_is_store <= 1'b0;
        end else if (grant_any) begin
            owner        <= grant_d;
            rr_ptr       <= ~grant_d;
            lat_vaddr    <= (grant_d == OWN_D) ? d_vaddr : i_vaddr;
            lat_is_store <= (grant_d == OWN_D) && d_is_store;
        end
    end

    // Capture the combinational TLB result during the single LOOKUP cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_hit       <= 1'b0;
            resp_paddr     <= 32'd0;
            resp_exc_valid <= 1'b0;
            resp_exc_code  <= 5'd0;
        end else if (in_lookup && !flush_kill) begin
            resp_hit       <= tlb_hit;
            resp_paddr     <= tlb_paddr;
            resp_exc_valid <= tlb_exc_valid;
            resp_exc_code  <= tlb_exc_code;
        end
    end

    // Saturating completion counters, stepped only on a real response handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_lookup_cnt <= '0;
            d_lookup_cnt <= '0;
            exc_cnt      <= '0;
        end else if (resp_fire) begin
            if (owner == OWN_I && i_lookup_cnt != CNT_MAX) begin
                i_lookup_cnt <= i_lookup_cnt + CNT_ONE;
            end
            if (owner == OWN_D && d_lookup_cnt != CNT_MAX) begin
                d_lookup_cnt <= d_lookup_cnt + CNT_ONE;
            end
            if (resp_exc_valid && exc_cnt != CNT_MAX) begin
                exc_cnt <= exc_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_tlb_lookup_arbiter.sv
// Bench for tlb_lookup_arbiter: two instances (round-robin/16-bit counters and D-priority/2-bit counters)
// share the same stimulus; a transaction-level model predicts every output each cycle.
// Directed scenarios come first, then randomized traffic with occasional resets.
module tb_tlb_lookup_arbiter;

    typedef struct packed {
        logic        hit;
        logic [31:0] pa;
        logic        exv;
        logic [4:0]  code;
    } tlb_res_t;

    // Simple TLB environment: top bits 11 miss, store to top bits 10 gives Mod,
    // everything else maps identically into the low 1 GB. ovr forces an exception.
    function automatic tlb_res_t xlate(input logic [31:0] va, input logic st,
                                       input logic ovr, input logic [4:0] ovr_code);
        tlb_res_t r;
        r.hit = 1'b1; r.pa = {2'b00, va[29:0]}; r.exv = 1'b0; r.code = 5'd0;
        if (ovr) begin
            r.hit = 1'b0; r.pa = 32'd0; r.exv = 1'b1; r.code = ovr_code;
        end else if (va[31:30] == 2'b11) begin
            r.hit = 1'b0; r.pa = 32'd0; r.exv = 1'b1; r.code = st ? 5'd3 : 5'd2;
        end else if (va[31:30] == 2'b10 && st) begin
            r.exv = 1'b1; r.code = 5'd1;
        end
        return r;
    endfunction

    logic clk = 1'b0;
    logic rst;
    logic i_req_valid, i_flush, i_resp_ready, d_req_valid, d_is_store, d_resp_ready;
    logic [31:0] i_vaddr, d_vaddr;
    logic ovr_en;
    logic [4:0] ovr_code;

    always #5 clk = ~clk;

    logic i_req_ready0, d_req_ready0, i_resp_valid0, d_resp_valid0;
    logic resp_hit0, resp_exc_valid0, tlb_req_valid0, tlb_is_store0;
    logic [31:0] resp_paddr0, tlb_vaddr0;
    logic [4:0] resp_exc_code0;
    logic [15:0] ic0, dc0, ec0;
    tlb_res_t tr0;
    assign tr0 = xlate(tlb_vaddr0, tlb_is_store0, ovr_en, ovr_code);

    logic i_req_ready1, d_req_ready1, i_resp_valid1, d_resp_valid1;
    logic resp_hit1, resp_exc_valid1, tlb_req_valid1, tlb_is_store1;
    logic [31:0] resp_paddr1, tlb_vaddr1;
    logic [4:0] resp_exc_code1;
    logic [1:0] ic1, dc1, ec1;
    tlb_res_t tr1;
    assign tr1 = xlate(tlb_vaddr1, tlb_is_store1, ovr_en, ovr_code);

    tlb_lookup_arbiter #(.D_PRIORITY(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready0), .i_vaddr(i_vaddr),
        .i_flush(i_flush), .i_resp_valid(i_resp_valid0), .i_resp_ready(i_resp_ready),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready0), .d_vaddr(d_vaddr),
        .d_is_store(d_is_store), .d_resp_valid(d_resp_valid0), .d_resp_ready(d_resp_ready),
        .resp_hit(resp_hit0), .resp_paddr(resp_paddr0),
        .resp_exc_valid(resp_exc_valid0), .resp_exc_code(resp_exc_code0),
        .tlb_req_valid(tlb_req_valid0), .tlb_vaddr(tlb_vaddr0), .tlb_is_store(tlb_is_store0),
        .tlb_hit(tr0.hit), .tlb_paddr(tr0.pa), .tlb_exc_valid(tr0.exv), .tlb_exc_code(tr0.code),
        .i_lookup_cnt(ic0), .d_lookup_cnt(dc0), .exc_cnt(ec0)
    );

    tlb_lookup_arbiter #(.D_PRIORITY(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready1), .i_vaddr(i_vaddr),
        .i_flush(i_flush), .i_resp_valid(i_resp_valid1), .i_resp_ready(i_resp_ready),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready1), .d_vaddr(d_vaddr),
        .d_is_store(d_is_store), .d_resp_valid(d_resp_valid1), .d_resp_ready(d_resp_ready),
        .resp_hit(resp_hit1), .resp_paddr(resp_paddr1),
        .resp_exc_valid(resp_exc_valid1), .resp_exc_code(resp_exc_code1),
        .tlb_req_valid(tlb_req_valid1), .tlb_vaddr(tlb_vaddr1), .tlb_is_store(tlb_is_store1),
        .tlb_hit(tr1.hit), .tlb_paddr(tr1.pa), .tlb_exc_valid(tr1.exv), .tlb_exc_code(tr1.code),
        .i_lookup_cnt(ic1), .d_lookup_cnt(dc1), .exc_cnt(ec1)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Transaction-level model, one slot per instance. age counts cycles since
    // accept: 1 is the TLB strobe cycle, 2 and later are response-waiting cycles.
    bit          m_busy [2];
    int          m_age  [2];
    bit          m_own  [2];   // 0 = I, 1 = D
    bit          m_rr   [2];   // 0 = I next, 1 = D next
    logic [31:0] m_va   [2];
    bit          m_st   [2];
    bit          m_hit  [2];
    logic [31:0] m_pa   [2];
    bit          m_exv  [2];
    logic [4:0]  m_code [2];
    int          m_ci   [2];
    int          m_cd   [2];
    int          m_ce   [2];
    int          m_max  [2] = '{65535, 3};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_age[k] = 0; m_own[k] = 0; m_rr[k] = 0;
            m_va[k] = 32'd0; m_st[k] = 0; m_hit[k] = 0; m_pa[k] = 32'd0;
            m_exv[k] = 0; m_code[k] = 5'd0; m_ci[k] = 0; m_cd[k] = 0; m_ce[k] = 0;
        end
    endtask

    // Which port wins this cycle: -1 none, 0 I, 1 D.
    function automatic int mgrant(input int k);
        bit ic = i_req_valid && !i_flush;
        bit dc = d_req_valid;
        if (rst || m_busy[k]) return -1;
        if (ic && dc) return (k == 1) ? 1 : int'(m_rr[k]);
        if (ic) return 0;
        if (dc) return 1;
        return -1;
    endfunction

    function automatic int sat_inc(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int g = mgrant(k);
            tlb_res_t r;
            if (g >= 0) begin
                m_busy[k] = 1; m_age[k] = 1; m_own[k] = (g == 1);
                m_va[k] = (g == 1) ? d_vaddr : i_vaddr;
                m_st[k] = (g == 1) ? d_is_store : 1'b0;
                m_rr[k] = (g == 0);
            end else if (m_busy[k]) begin
                if (!m_own[k] && i_flush) begin
                    m_busy[k] = 0;
                end else if (m_age[k] == 1) begin
                    r = xlate(m_va[k], m_st[k], ovr_en, ovr_code);
                    m_hit[k] = r.hit; m_pa[k] = r.pa; m_exv[k] = r.exv; m_code[k] = r.code;
                    m_age[k] = 2;
                end else if (m_own[k] ? d_resp_ready : i_resp_ready) begin
                    m_busy[k] = 0;
                    if (m_own[k]) m_cd[k] = sat_inc(m_cd[k], m_max[k]);
                    else          m_ci[k] = sat_inc(m_ci[k], m_max[k]);
                    if (m_exv[k]) m_ce[k] = sat_inc(m_ce[k], m_max[k]);
                end else begin
                    m_age[k] = m_age[k] + 1;
                end
            end
        end
    endtask

    task automatic check_dut(input int k, input logic irr, input logic drr,
                             input logic ivl, input logic dvl, input logic hit,
                             input logic [31:0] pa, input logic exv, input logic [4:0] code,
                             input logic tv, input logic [31:0] tva, input logic ts,
                             input logic [31:0] ic, input logic [31:0] dc, input logic [31:0] ec);
        string p = $sformatf("dut%0d.", k);
        int g = mgrant(k);
        bit rphase = m_busy[k] && (m_age[k] >= 2);
        chk({p, "i_req_ready"},    32'(irr),  32'(g == 0));
        chk({p, "d_req_ready"},    32'(drr),  32'(g == 1));
        chk({p, "i_resp_valid"},   32'(ivl),  32'(rphase && !m_own[k] && !i_flush));
        chk({p, "d_resp_valid"},   32'(dvl),  32'(rphase && m_own[k]));
        chk({p, "resp_hit"},       32'(hit),  32'(m_hit[k]));
        chk({p, "resp_paddr"},     pa,        m_pa[k]);
        chk({p, "resp_exc_valid"}, 32'(exv),  32'(m_exv[k]));
        chk({p, "resp_exc_code"},  32'(code), 32'(m_code[k]));
        chk({p, "tlb_req_valid"},  32'(tv),   32'(m_busy[k] && m_age[k] == 1));
        chk({p, "tlb_vaddr"},      tva,       m_va[k]);
        chk({p, "tlb_is_store"},   32'(ts),   32'(m_st[k]));
        chk({p, "i_lookup_cnt"},   ic,        32'(m_ci[k]));
        chk({p, "d_lookup_cnt"},   dc,        32'(m_cd[k]));
        chk({p, "exc_cnt"},        ec,        32'(m_ce[k]));
    endtask

    // Let inputs settle, then compare both instances against the model.
    task automatic settle();
        #1;
        check_dut(0, i_req_ready0, d_req_ready0, i_resp_valid0, d_resp_valid0, resp_hit0,
                  resp_paddr0, resp_exc_valid0, resp_exc_code0, tlb_req_valid0, tlb_vaddr0,
                  tlb_is_store0, 32'(ic0), 32'(dc0), 32'(ec0));
        check_dut(1, i_req_ready1, d_req_ready1, i_resp_valid1, d_resp_valid1, resp_hit1,
                  resp_paddr1, resp_exc_valid1, resp_exc_code1, tlb_req_valid1, tlb_vaddr1,
                  tlb_is_store1, 32'(ic1), 32'(dc1), 32'(ec1));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic iv, input logic [31:0] ia, input logic fl, input logic irr,
                         input logic dv, input logic [31:0] da, input logic ds, input logic drr);
        i_req_valid = iv; i_vaddr = ia; i_flush = fl; i_resp_ready = irr;
        d_req_valid = dv; d_vaddr = da; d_is_store = ds; d_resp_ready = drr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        settle();
        @(negedge clk);
        drive(0, 32'd0, 0, 0, 0, 32'd0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ovr_en = 1'b0;
        ovr_code = 5'd0;
        drive(0, 32'd0, 0, 0, 0, 32'd0, 0, 0);
        model_reset();
        @(negedge clk);
        settle();
        chk("reset.resp_paddr", resp_paddr0, 32'd0);
        chk("reset.i_lookup_cnt", 32'(ic0), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single I lookup: accept T, strobe T+1, response T+2.
        drive(1, 32'h0000_1234, 0, 1, 0, 32'd0, 0, 0);
        settle(); chk("s1.i_req_ready", 32'(i_req_ready0), 32'd1); tick();
        drive(0, 32'd0, 0, 1, 0, 32'd0, 0, 0);
        settle();
        chk("s1.tlb_req_valid", 32'(tlb_req_valid0), 32'd1);
        chk("s1.tlb_vaddr", tlb_vaddr0, 32'h0000_1234);
        chk("s1.tlb_is_store", 32'(tlb_is_store0), 32'd0);
        tick();
        settle();
        chk("s1.i_resp_valid", 32'(i_resp_valid0), 32'd1);
        chk("s1.resp_paddr", resp_paddr0, 32'h0000_1234);
        chk("s1.resp_hit", 32'(resp_hit0), 32'd1);
        tick();
        settle(); chk("s1.i_lookup_cnt", 32'(ic0), 32'd1); tick();

        // Round-robin contention from reset: I, D, I, D.
        do_reset();
        for (int k = 0; k < 12; k++) begin
            drive(1, 32'h100 + 32'(k * 4), 0, 1, 1, 32'h2000 + 32'(k * 4), k[0], 1);
            settle();
            if (k % 3 == 0) begin
                chk("s2.i_grant", 32'(i_req_ready0), 32'((k / 3) % 2 == 0));
                chk("s2.d_grant", 32'(d_req_ready0), 32'((k / 3) % 2 == 1));
            end
            tick();
        end
        drive(0, 32'd0, 0, 1, 0, 32'd0, 0, 1);
        settle();
        chk("s2.i_lookup_cnt", 32'(ic0), 32'd2);
        chk("s2.d_lookup_cnt", 32'(dc0), 32'd2);
        tick();

        // D store with a forced TLBS exception, response held under backpressure.
        ovr_en = 1'b1; ovr_code = 5'd3;
        drive(0, 32'd0, 0, 0, 1, 32'h0000_5000, 1, 0);
        settle(); chk("s3.d_req_ready", 32'(d_req_ready0), 32'd1); tick();
        drive(0, 32'd0, 0, 0, 0, 32'd0, 0, 0);
        settle(); chk("s3.tlb_is_store", 32'(tlb_is_store0), 32'd1); tick();
        for (int j = 0; j < 3; j++) begin
            settle();
            chk("s3.d_resp_valid", 32'(d_resp_valid0), 32'd1);
            chk("s3.resp_exc_valid", 32'(resp_exc_valid0), 32'd1);
            chk("s3.resp_exc_code", 32'(resp_exc_code0), 32'd3);
            tick();
        end
        drive(0, 32'd0, 0, 0, 0, 32'd0, 0, 1);
        settle(); chk("s3.d_resp_valid_last", 32'(d_resp_valid0), 32'd1); tick();
        drive(0, 32'd0, 0, 0, 0, 32'd0, 0, 0);
        settle();
        chk("s3.exc_cnt", 32'(ec0), 32'd1);
        chk("s3.d_lookup_cnt", 32'(dc0), 32'd3);
        tick();
        ovr_en = 1'b0; ovr_code = 5'd0;

        // I flushed during LOOKUP; the pending D request is taken at T+2.
        drive(1, 32'h0000_4444, 0, 1, 0, 32'd0, 0, 0);
        settle(); chk("s4.i_req_ready", 32'(i_req_ready0), 32'd1); tick();
        drive(0, 32'd0, 1, 1, 1, 32'h0000_6000, 0, 1);
        settle();
        chk("s4.tlb_req_valid", 32'(tlb_req_valid0), 32'd1);
        chk("s4.d_blocked", 32'(d_req_ready0), 32'd0);
        tick();
        drive(0, 32'd0, 0, 1, 1, 32'h0000_6000, 0, 1);
        settle();
        chk("s4.i_resp_valid", 32'(i_resp_valid0), 32'd0);
        chk("s4.d_req_ready", 32'(d_req_ready0), 32'd1);
        chk("s4.i_lookup_cnt", 32'(ic0), 32'd2);
        tick();
        drive(0, 32'd0, 0, 0, 0, 32'd0, 0, 1);
        settle(); tick();
        settle(); chk("s4.d_resp_valid", 32'(d_resp_valid0), 32'd1); tick();
        settle(); chk("s4.d_lookup_cnt", 32'(dc0), 32'd4); tick();

        // Fixed D priority: I never granted; then reset lands in RESP.
        for (int k = 0; k < 9; k++) begin
            drive(1, 32'h7000 + 32'(k), 0, 1, 1, 32'h8000 + 32'(k), 0, 1);
            settle();
            chk("s5.i_req_ready", 32'(i_req_ready1), 32'd0);
            if (k % 3 == 0) chk("s5.d_req_ready", 32'(d_req_ready1), 32'd1);
            tick();
        end
        drive(1, 32'h7009, 0, 0, 1, 32'h8009, 0, 0);
        settle(); chk("s5.d_req_ready_last", 32'(d_req_ready1), 32'd1); tick();
        settle(); tick();
        settle(); chk("s5.d_resp_valid", 32'(d_resp_valid1), 32'd1);
        rst = 1'b1;
        model_reset();
        settle();
        chk("s5.rst_d_resp_valid", 32'(d_resp_valid1), 32'd0);
        chk("s5.rst_resp_paddr", resp_paddr1, 32'd0);
        chk("s5.rst_tlb_vaddr", tlb_vaddr1, 32'd0);
        chk("s5.rst_d_lookup_cnt", 32'(dc1), 32'd0);
        chk("s5.rst_d_req_ready", 32'(d_req_ready1), 32'd0);
        @(negedge clk);
        drive(0, 32'd0, 0, 0, 0, 32'd0, 0, 0);
        rst = 1'b0;

        // Five I completions: 2-bit counter saturates at 3.
        for (int k = 0; k < 15; k++) begin
            drive(1, 32'h9000 + 32'(k * 16), 0, 1, 0, 32'd0, 0, 0);
            settle();
            tick();
        end
        drive(0, 32'd0, 0, 0, 0, 32'd0, 0, 0);
        settle();
        chk("s6.i_lookup_cnt_sat", 32'(ic1), 32'd3);
        chk("s6.i_lookup_cnt_wide", 32'(ic0), 32'd5);
        tick();

        // Randomized traffic including flushes, stores, misses and resets.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end
            drive(1'($urandom_range(0, 1)), $urandom(), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom(),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
            settle();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
